// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop sync, 3-sample majority vote,
// optional parity, 1-2 stop bits, valid/ready output with overrun flag.
module uart_rx_param #(
    parameter int BAUD_CNT_MAX = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int CW = $clog2(BAUD_CNT_MAX);
    localparam int H  = BAUD_CNT_MAX / 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_VOTE = CW'(H + 1);

    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic       ODD       = (PARITY == 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic           rx_meta;
    logic           rx_sync;
    logic           rx_prev;
    logic [1:0]     fill;
    logic           fall;

    logic [CW-1:0]  cnt;
    logic [2:0]     bit_cnt;
    logic           s0;
    logic           s1;
    logic           vote;
    logic           vote_pt;
    logic           baud_wrap;
    logic           done;

    logic [DATA_BITS-1:0] sh;
    logic           all_zero;
    logic           perr_acc;
    logic           ferr_acc;
    logic           brk_acc;
    logic           ferr_c;
    logic           brk_c;

    // Resynchronise rx; fill gates edges until the chain holds real samples
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            fill    <= 2'd0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (fill != 2'd3) begin
                fill <= fill + 2'd1;
            end
        end
    end

    assign fall      = (fill == 2'd3) & rx_prev & ~rx_sync;
    assign baud_wrap = (cnt == CNT_LAST);
    assign vote_pt   = (cnt == CNT_VOTE);
    assign vote      = (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);

    assign ferr_c = ferr_acc | ~vote;
    assign brk_c  = (bit_cnt == 3'd0) ? (all_zero & ~vote) : brk_acc;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and frame-completion strobe
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (vote_pt && vote) begin
                    state_d = ST_IDLE;
                end else if (baud_wrap) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_wrap && bit_cnt == DATA_LAST) begin
                    state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (baud_wrap) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (vote_pt && bit_cnt == STOP_LAST) begin
                    done    = 1'b1;
                    state_d = vote ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_sync) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Baud/bit counters, sampling and per-frame accumulation
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt      <= '0;
            bit_cnt  <= '0;
            s0       <= 1'b0;
            s1       <= 1'b0;
            sh       <= '0;
            all_zero <= 1'b0;
            perr_acc <= 1'b0;
            ferr_acc <= 1'b0;
            brk_acc  <= 1'b0;
        end else begin
            if (state_q == ST_IDLE || state_q == ST_WAIT_IDLE) begin
                cnt <= '0;
            end else if (baud_wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (cnt == CNT_S0) begin
                s0 <= rx_sync;
            end
            if (cnt == CNT_S1) begin
                s1 <= rx_sync;
            end

            if (state_q != state_d) begin
                bit_cnt <= '0;
            end else if (baud_wrap &&
                         (state_q == ST_DATA || state_q == ST_STOP)) begin
                bit_cnt <= bit_cnt + 3'd1;
            end

            if (state_q == ST_IDLE && fall) begin
                all_zero <= 1'b1;
                perr_acc <= 1'b0;
                ferr_acc <= 1'b0;
                brk_acc  <= 1'b0;
            end

            if (state_q == ST_DATA && vote_pt) begin
                sh <= {vote, sh[DATA_BITS-1:1]};
                if (vote) begin
                    all_zero <= 1'b0;
                end
            end

            if (state_q == ST_PARITY && vote_pt) begin
                perr_acc <= ((^sh) ^ vote) != ODD;
                if (vote) begin
                    all_zero <= 1'b0;
                end
            end

            if (state_q == ST_STOP && vote_pt) begin
                if (!vote) begin
                    ferr_acc <= 1'b1;
                end
                if (bit_cnt == 3'd0) begin
                    brk_acc <= all_zero & ~vote;
                end
            end
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!valid || ready) begin
                    data       <= sh;
                    parity_err <= perr_acc;
                    frame_err  <= ferr_c;
                    break_det  <= brk_c;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1 and 7O1 instances, vector table feeding
// a scoreboard, plus glitch/break/overrun/reset sequences.
module tb_uart_rx_param;

    localparam int BAUD = 16;

    logic       clk;
    logic       reset_n;
    logic       rx8;
    logic       rx7;
    logic       ready8;
    logic       ready7;
    logic [7:0] data8;
    logic [6:0] data7;
    logic       valid8, perr8, ferr8, brk8, ovr8;
    logic       valid7, perr7, ferr7, brk7, ovr7;

    uart_rx_param #(
        .BAUD_CNT_MAX(BAUD),
        .DATA_BITS(8),
        .PARITY(0),
        .STOP_BITS(1)
    ) dut8 (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx8),
        .data(data8),
        .valid(valid8),
        .ready(ready8),
        .parity_err(perr8),
        .frame_err(ferr8),
        .break_det(brk8),
        .overrun(ovr8)
    );

    uart_rx_param #(
        .BAUD_CNT_MAX(BAUD),
        .DATA_BITS(7),
        .PARITY(2),
        .STOP_BITS(1)
    ) dut7 (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx7),
        .data(data7),
        .valid(valid7),
        .ready(ready7),
        .parity_err(perr7),
        .frame_err(ferr7),
        .break_det(brk7),
        .overrun(ovr7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
        logic       b;
    } exp_t;

    typedef struct {
        int         line;
        logic [7:0] d;
        int         par;
        logic       stop_v;
        logic [7:0] ed;
        logic       ep;
        logic       ef;
        logic       eb;
    } vec_t;

    exp_t q8[$];
    exp_t q7[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int words8   = 0;
    int words7   = 0;
    int ovr_cnt8 = 0;
    int rise8    = 0;
    int width8   = 0;
    logic v8_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop an expected word on each handshake
    always @(negedge clk) begin
        exp_t e;
        if (valid8 && !v8_prev) rise8 = cyc;
        if (!valid8 && v8_prev) width8 = cyc - rise8;
        v8_prev = valid8;
        if (ovr8) ovr_cnt8++;
        if (valid8 && ready8) begin
            words8++;
            if (q8.size() == 0) begin
                check("unexpected_word8", {24'd0, data8}, 32'hFFFF);
            end else begin
                e = q8.pop_front();
                check("data8", {24'd0, data8}, {24'd0, e.d});
                check("perr8", {31'd0, perr8}, {31'd0, e.p});
                check("ferr8", {31'd0, ferr8}, {31'd0, e.f});
                check("brk8", {31'd0, brk8}, {31'd0, e.b});
            end
        end
        if (valid7 && ready7) begin
            words7++;
            if (q7.size() == 0) begin
                check("unexpected_word7", {25'd0, data7}, 32'hFFFF);
            end else begin
                e = q7.pop_front();
                check("data7", {25'd0, data7}, {24'd0, e.d});
                check("perr7", {31'd0, perr7}, {31'd0, e.p});
                check("ferr7", {31'd0, ferr7}, {31'd0, e.f});
                check("brk7", {31'd0, brk7}, {31'd0, e.b});
            end
        end
    end

    task automatic drive(input int line, input logic v);
        if (line == 0) rx8 = v;
        else rx7 = v;
    endtask

    task automatic send_bits(input int line, input logic [15:0] b,
                             input int n);
        @(negedge clk);
        t0 = cyc;
        for (int i = 0; i < n; i++) begin
            drive(line, b[i]);
            repeat (BAUD) @(negedge clk);
        end
    endtask

    task automatic send_frame(input int line, input logic [7:0] d,
                              input int par, input logic stop_v);
        logic [15:0] b;
        int n;
        int nb;
        nb = (line == 0) ? 8 : 7;
        b = '1;
        n = 0;
        b[n] = 1'b0;
        n++;
        for (int i = 0; i < nb; i++) begin
            b[n] = d[i];
            n++;
        end
        if (par >= 0) begin
            b[n] = par[0];
            n++;
        end
        b[n] = stop_v;
        n++;
        n += 2;
        send_bits(line, b, n);
    endtask

    task automatic wait_drain;
        int k;
        k = 0;
        while ((q8.size() != 0 || q7.size() != 0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("drain_q8", q8.size(), 0);
        check("drain_q7", q7.size(), 0);
    endtask

    task automatic push8(input logic [7:0] d, input logic p,
                         input logic f, input logic b);
        q8.push_back({d, p, f, b});
    endtask

    vec_t vecs[10];

    initial begin
        #2000000;
        $display("FAIL watchdog cycles=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int base;
        int obase;
        logic [15:0] pb;

        vecs[0] = '{0, 8'hFF, -1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h00, -1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{0, 8'h81, -1, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{0, 8'h5A, -1, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{0, 8'h00, -1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1, 8'h35, 1, 1'b1, 8'h35, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1, 8'h35, 0, 1'b1, 8'h35, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1, 8'h00, 1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1, 8'h00, 0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1, 8'h7F, 0, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0};

        reset_n = 1'b0;
        rx8     = 1'b1;
        rx7     = 1'b1;
        ready8  = 1'b1;
        ready7  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid8", {31'd0, valid8}, 0);
        check("rst_data8", {24'd0, data8}, 0);
        check("rst_flags8", {28'd0, perr8, ferr8, brk8, ovr8}, 0);
        check("rst_valid7", {31'd0, valid7}, 0);
        check("rst_flags7", {28'd0, perr7, ferr7, brk7, ovr7}, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2 * BAUD) @(negedge clk);

        // 8N1 0xA5: latency from start edge and single-cycle valid
        width8 = 0;
        push8(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'hA5, -1, 1'b1);
        check("lat_a5", rise8 - t0, 157);
        check("width_a5", width8, 1);

        // table-driven frames on both instances
        foreach (vecs[i]) begin
            if (vecs[i].line == 0) begin
                push8(vecs[i].ed, vecs[i].ep, vecs[i].ef, vecs[i].eb);
            end else begin
                q7.push_back({vecs[i].ed, vecs[i].ep, vecs[i].ef,
                              vecs[i].eb});
            end
            send_frame(vecs[i].line, vecs[i].d, vecs[i].par,
                       vecs[i].stop_v);
        end
        wait_drain();
        check("words7", words7, 5);

        // 4-cycle glitch: rejected, then 0x3C received
        base = words8;
        @(negedge clk);
        rx8 = 1'b0;
        repeat (4) @(negedge clk);
        rx8 = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        check("glitch_nowords", words8 - base, 0);
        push8(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h3C, -1, 1'b1);
        wait_drain();

        // break: 20 bit times low gives exactly one flagged word
        base = words8;
        push8(8'h00, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        rx8 = 1'b0;
        repeat (20 * BAUD) @(negedge clk);
        check("break_one_word", words8 - base, 1);
        rx8 = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        check("break_no_more", words8 - base, 1);
        push8(8'h96, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h96, -1, 1'b1);
        wait_drain();
        check("break_next", words8 - base, 2);

        // overrun: two frames with ready low
        @(posedge clk);
        #1 ready8 = 1'b0;
        obase = ovr_cnt8;
        push8(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h11, -1, 1'b1);
        check("ovr_none_yet", ovr_cnt8 - obase, 0);
        send_frame(0, 8'h22, -1, 1'b1);
        check("ovr_once", ovr_cnt8 - obase, 1);
        check("ovr_valid", {31'd0, valid8}, 1);
        check("ovr_held", {24'd0, data8}, 32'h11);
        @(posedge clk);
        #1 ready8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_cleared", {31'd0, valid8}, 0);
        wait_drain();

        // reset mid-DATA with a held flagged word
        @(posedge clk);
        #1 ready8 = 1'b0;
        send_frame(0, 8'h00, -1, 1'b0);
        check("pre_rst_valid", {31'd0, valid8}, 1);
        check("pre_rst_flags", {30'd0, ferr8, brk8}, 3);
        pb = 16'b0000_0000_0000_0100;
        send_bits(0, pb, 4);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_valid", {31'd0, valid8}, 0);
        check("mid_rst_data", {24'd0, data8}, 0);
        check("mid_rst_flags", {28'd0, perr8, ferr8, brk8, ovr8}, 0);
        base = words8;
        @(posedge clk);
        #1 reset_n = 1'b1;
        ready8 = 1'b1;
        repeat (3 * BAUD) @(negedge clk);
        check("low_after_rst", {31'd0, valid8}, 0);
        rx8 = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        check("low_no_words", words8 - base, 0);
        push8(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h5A, -1, 1'b1);
        wait_drain();
        check("post_rst_word", words8 - base, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter BAUD_CNT_MAX, default 5208, meaning clk cycles per bit (legal 8..16383).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..8).
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 none / 1 even / 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked (legal 1 or 2).
REQ-005 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  meaning the synchronous, active-low reset.
REQ-007 SHALL have port rx  input  1  meaning the asynchronous serial line, idle high.
REQ-008 SHALL have port data  output  DATA_BITS  meaning the received word, LSB received first.
REQ-009 SHALL have port valid  output  1  meaning data and flags are held valid.
REQ-010 SHALL have port ready  input  1  meaning the consumer accepts data when valid&&ready.
REQ-011 SHALL have port parity_err  output  1  meaning the parity mismatch for the held word (0 when PARITY=0).
REQ-012 SHALL have port frame_err  output  1  meaning a stop bit sampled 0 for the held word.
REQ-013 SHALL have port break_det  output  1  meaning the held frame was all-zero including parity and stop.
REQ-014 SHALL have port overrun  output  1  meaning a one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL synchronise rx through two flops (reset value 1) and detect a falling edge on the synchronised value.
REQ-016 SHALL have FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-017 SHALL have a baud counter that runs 0..BAUD_CNT_MAX-1 in every non-IDLE/non-WAIT_IDLE state, cleared on state entry from IDLE and on wrap.
REQ-018 SHALL take samples at counts H-1, H, H+1 (H=BAUD_CNT_MAX/2); the bit value is the 2-of-3 majority, decided at count H+1.
REQ-019 SHALL go IDLE->START on a falling edge; ignore edges in all other states.
REQ-020 SHALL, in START, return to IDLE if the start vote is 1 (glitch rejection), with no output change; otherwise go to DATA at the bit wrap.
REQ-021 SHALL, in DATA, shift the votes LSB-first into the shift register; after DATA_BITS votes go to PARITY if PARITY!=0, else to STOP.
REQ-022 SHALL, in PARITY, compute error = (XOR of data bits ^ parity vote) != (PARITY==2).
REQ-023 SHALL, in STOP, vote each of STOP_BITS stop bits; frame_err when any stop vote is 0; complete the frame at the decision point of the last stop bit, not waiting for its end.
REQ-024 SHALL, on completion, go to IDLE if the last stop vote is 1, else to WAIT_IDLE until the synchronised rx is 1, then IDLE.
REQ-025 SHALL set break_det when all data votes, the parity vote (if any) and the first stop vote are 0.
REQ-026 SHALL, on completion with valid=0 or ready=1 in the same cycle, load data/flags and set valid the next cycle; latency is one clk from the final stop decision.
REQ-027 SHALL keep valid/data/flags stable until valid&&ready; valid then clears unless a completion occurs in the same cycle (the new word loads, valid stays 1).
REQ-028 SHALL, on completion with valid=1 and ready=0, drop the new frame, keep the held word, and pulse overrun for one cycle.
REQ-029 SHALL deliver frames with errors normally, with flags attached.

Reset
REQ-030 SHALL, when reset_n=0 at a rising clk edge, go to IDLE, set synchroniser flops to 1, set baud/bit counters, shift register and data to 0, and set valid, parity_err, frame_err, break_det and overrun to 0.
REQ-031 SHALL abandon a frame interrupted by reset mid-operation with no output; after release, a low rx line produces no start until a new falling edge.

Verification (BAUD_CNT_MAX=16)
REQ-032 SHALL cover: 8N1 frame 0xA5 with ready=1 -> valid one cycle, data=0xA5, all flags 0, valid one clk after the stop decision.
REQ-033 SHALL cover: DATA_BITS=7, PARITY=2, frame 0x35 with parity bit 1 -> parity_err=0; the same frame with parity bit 0 -> parity_err=1.
REQ-034 SHALL cover: a 4-cycle low glitch on an idle line -> no valid and the FSM back in IDLE; the next proper frame 0x3C is received correctly.
REQ-035 SHALL cover: rx held low for 20 bit times -> one word data=0x00 with frame_err=1 and break_det=1, then no further word until rx returns high and a new frame arrives.
REQ-036 SHALL cover: two frames 0x11, 0x22 with ready=0 -> data=0x11 held, overrun pulses once at the second completion; raise ready -> valid clears.
REQ-037 SHALL cover: reset_n=0 asserted mid-DATA -> all outputs 0 next cycle; after release, frame 0x5A is received correctly.
